// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Purpose  : Shared constants and types for the multiplexed 7-segment
//             scan driver: blank pattern, hex glyph table, digit limits.
//  Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

   // All segments and the decimal point off (active-low drive)
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Glyph field with every segment off; decimal point handled separately
   localparam logic [6:0] GLYPH_OFF = 7'h7F;

   // Supported digit-bank sizes
   localparam int DIGITS_MIN = 1;
   localparam int DIGITS_MAX = 8;

   // Active-low g..a glyphs for nibbles 0..F (entry 15 listed first)
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // Phase within a digit slot
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_ON    = 1'b1
   } slot_phase_e;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_dec
//  Purpose  : Combinational nibble to active-low 7-segment glyph decoder.
//             With hex_en low, nibbles 10..15 decode to an unlit digit.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_dec
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_en,
   output logic [6:0] glyph
);

   // Table lookup, overridden to dark for letters when hex display is off
   always_comb begin
      glyph = HEX_GLYPH[nibble];
      if (!hex_en && (nibble > 4'd9)) begin
         glyph = GLYPH_OFF;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Multiplexed common-anode 7-segment scan driver. Walks the digit
//             bank one slot at a time, blanks the start of each slot to stop
//             ghosting, optionally hides leading zeros, and latches the input
//             image once per frame so a frame never mixes old and new data.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 500,
   parameter bit HEX_EN     = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank_lz,
   output logic [NUM_DIGITS-1:0]   wei_en,
   output logic [7:0]              duan,
   output logic                    frame_done
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Scan counters
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic             div_last, idx_last;

   // Frame snapshot of the displayed image
   logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q,   dp_sh_d;
   logic                    snap_load;

   // Decode path
   logic                  in_blank;
   slot_phase_e           phase;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_run;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic [6:0]            glyph;

   // Registered outputs
   logic [NUM_DIGITS-1:0] wei_en_q, wei_en_d;
   logic [7:0]            duan_q,   duan_d;
   logic                  frame_done_q, frame_done_d;

   assign div_last = (div_cnt_q == DIV_LAST);
   assign idx_last = (idx_q == IDX_LAST);

   // Blanking gap test; with no gap the slot is lit from its first cycle
   if (BLANK_CYC > 0) begin : g_blank_gap
      localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);
      assign in_blank = (div_cnt_q < BLANK_LIM);
   end else begin : g_no_gap
      assign in_blank = 1'b0;
   end

   // Slot prescaler and digit index advance
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      idx_d     = idx_q;
      if (div_last) begin
         div_cnt_d = '0;
         idx_d     = idx_last ? '0 : idx_q + 1'b1;
      end
   end

   // Snapshot capture at the first cycle of every frame; decode sees the
   // value being captured so the opening slot already shows the new frame
   always_comb begin
      snap_load = (div_cnt_q == '0) && (idx_q == '0);
      data_sh_d = snap_load ? data : data_sh_q;
      dp_sh_d   = snap_load ? dp   : dp_sh_q;
   end

   // Leading-zero mask, scanning from the most significant digit down
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (data_sh_d[4*i +: 4] == 4'h0);
         if (i != 0) begin
            lz_mask[i] = zero_run & blank_lz;
         end
      end
   end

   assign cur_nib = data_sh_d[{idx_q, 2'b00} +: 4];
   assign cur_dp  = dp_sh_d[idx_q];

   seg7_hex_dec u_dec (
      .nibble (cur_nib),
      .hex_en (HEX_EN),
      .glyph  (glyph)
   );

   // Next output image from the current counter state
   always_comb begin
      phase        = in_blank ? PH_BLANK : PH_ON;
      wei_en_d     = '1;
      duan_d       = SEG_BLANK;
      frame_done_d = div_last && idx_last;
      if (phase == PH_ON) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            wei_en_d[i] = (idx_q != IDX_W'(i));
         end
         duan_d = {~cur_dp, lz_mask[idx_q] ? GLYPH_OFF : glyph};
      end
   end

   // State and output registers; enables and segments update together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         idx_q        <= '0;
         data_sh_q    <= '0;
         dp_sh_q      <= '0;
         wei_en_q     <= '1;
         duan_q       <= SEG_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         data_sh_q    <= data_sh_d;
         dp_sh_q      <= dp_sh_d;
         wei_en_q     <= wei_en_d;
         duan_q       <= duan_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wei_en     = wei_en_q;
   assign duan       = duan_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Directed self-checking bench for seg_scan_ctrl. Main instance
//             4 digits / SCAN_DIV 8 / BLANK_CYC 2, a HEX_EN=0 twin, and a
//             single-digit instance with no blanking gap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  dp;
   logic        blank_lz;

   logic [3:0]  wei_en;
   logic [7:0]  duan;
   logic        frame_done;

   logic [3:0]  wei_en_nh;
   logic [7:0]  duan_nh;
   logic        frame_done_nh;

   logic [0:0]  wei_en_1d;
   logic [7:0]  duan_1d;
   logic        frame_done_1d;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_cnt;

   always #5 clk = ~clk;

   // Posedges since reset release: after edge k the outputs reflect cycle k-1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_lz(blank_lz),
      .wei_en(wei_en), .duan(duan), .frame_done(frame_done)
   );

   seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_EN(1'b0)) dut_nh (
      .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank_lz(blank_lz),
      .wei_en(wei_en_nh), .duan(duan_nh), .frame_done(frame_done_nh)
   );

   seg_scan_ctrl #(.NUM_DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(0), .HEX_EN(1'b1)) dut_1d (
      .clk(clk), .rst_n(rst_n), .data(data[3:0]), .dp(dp[0:0]), .blank_lz(blank_lz),
      .wei_en(wei_en_1d), .duan(duan_1d), .frame_done(frame_done_1d)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [3:0] w, input logic [7:0] d, input logic f);
      chk({tag, "_wei"},  16'(wei_en),     16'(w));
      chk({tag, "_duan"}, 16'(duan),       16'(d));
      chk({tag, "_fd"},   16'(frame_done), 16'(f));
   endtask

   task automatic goto_edge(input int k);
      while (edge_cnt < k) @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      data     = 16'h0000;
      dp       = 4'h0;
      blank_lz = 1'b0;

      // Reset held while inputs move
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data     = 16'($urandom);
         dp       = 4'($urandom);
         blank_lz = ~blank_lz;
         @(negedge clk);
         chk3("rst_hold", 4'hF, 8'hFF, 1'b0);
      end

      // Frame 0/1: 1234, no dp, no leading-zero blanking
      data     = 16'h1234;
      dp       = 4'h0;
      blank_lz = 1'b0;
      rst_n    = 1'b1;

      goto_edge(1);  chk3("f0_c0_blank", 4'hF, 8'hFF, 1'b0);
                     chk("d1_e1_wei", 16'(wei_en_1d), 16'h0);
      goto_edge(2);  chk("d1_e2_duan", 16'(duan_1d), 16'h0099);
      goto_edge(3);  chk3("f0_d0_on", 4'hE, 8'h99, 1'b0);
                     chk("nh_d0", 16'(duan_nh), 16'h0099);
      goto_edge(4);  chk("d1_e4_fd", 16'(frame_done_1d), 16'h1);
      goto_edge(5);  chk("d1_e5_fd", 16'(frame_done_1d), 16'h0);
      goto_edge(8);  chk3("f0_d0_last", 4'hE, 8'h99, 1'b0);
                     chk("d1_e8_fd", 16'(frame_done_1d), 16'h1);
      goto_edge(9);  chk3("f0_d1_blank", 4'hF, 8'hFF, 1'b0);
      goto_edge(11); chk3("f0_d1_on", 4'hD, 8'hB0, 1'b0);
      goto_edge(19); chk3("f0_d2_on", 4'hB, 8'hA4, 1'b0);
      goto_edge(27); chk3("f0_d3_on", 4'h7, 8'hF9, 1'b0);
      goto_edge(32); chk3("f0_end", 4'h7, 8'hF9, 1'b1);
      goto_edge(33); chk3("f1_start", 4'hF, 8'hFF, 1'b0);

      // Inputs change in the middle of frame 1; frame 1 keeps old image
      goto_edge(42);
      data     = 16'h00A5;
      dp       = 4'h0;
      blank_lz = 1'b1;
      goto_edge(51); chk3("mid_d2_old", 4'hB, 8'hA4, 1'b0);
      goto_edge(59); chk3("mid_d3_old", 4'h7, 8'hF9, 1'b0);

      // Frame 2: 00A5 with leading-zero blanking
      goto_edge(67); chk3("a5_d0", 4'hE, 8'h92, 1'b0);
      goto_edge(75); chk3("a5_d1", 4'hD, 8'h88, 1'b0);
                     chk("nh_a5_d1", 16'(duan_nh), 16'h00FF);
      goto_edge(83); chk3("a5_d2_lz", 4'hB, 8'hFF, 1'b0);
      goto_edge(91); chk3("a5_d3_lz", 4'h7, 8'hFF, 1'b0);
      data = 16'h0000;
      dp   = 4'b0100;
      goto_edge(96); chk3("a5_end", 4'h7, 8'hFF, 1'b1);

      // Frame 3: all zero, dp on digit 2
      goto_edge(99);  chk3("z_d0", 4'hE, 8'hC0, 1'b0);
      goto_edge(107); chk3("z_d1", 4'hD, 8'hFF, 1'b0);
      goto_edge(115); chk3("z_d2_dp", 4'hB, 8'h7F, 1'b0);
      goto_edge(123); chk3("z_d3", 4'h7, 8'hFF, 1'b0);

      // Reset in the middle of a lit slot
      goto_edge(134); chk3("pre_rst", 4'hE, 8'hC0, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk3("rst_async", 4'hF, 8'hFF, 1'b0);
      data     = 16'h1234;
      dp       = 4'h0;
      blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      chk3("rst_held2", 4'hF, 8'hFF, 1'b0);
      rst_n = 1'b1;

      goto_edge(2);  chk3("rel_blank", 4'hF, 8'hFF, 1'b0);
      goto_edge(3);  chk3("rel_d0_on", 4'hE, 8'h99, 1'b0);
      goto_edge(31); chk("rel_fd_early", 16'(frame_done), 16'h0);
      goto_edge(32); chk("rel_fd", 16'(frame_done), 16'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
